ps2_mouse_init_ctrl: RTL and testbench
======================================

// Module: ps2_mouse_init_ctrl
// PURPOSE
//   Power-up/restart sequencer for the PS/2 mouse. Drives the byte-level PS/2 transmitter and
//   consumes bytes from the PS/2 receiver. Sends RESET, set-sample-rate and ENABLE, checking every
//   response with timeouts and bounded retries. When the sequence completes, it asserts stream_en,
//   which gates the movement-packet/cell-tracking datapath.
// PARAMETERS
//   ACK_TIMEOUT  1_000_000   cycles to wait for a response byte after a command (20 ms @ 50 MHz)
//   BAT_TIMEOUT  37_500_000  cycles to wait for BAT 0xAA and ID 0x00 after ACK of RESET (750 ms)
//   MAX_RETRIES  3           failed attempts allowed before FAIL (1..3)
//   SAMPLE_RATE  8'd100      argument byte sent after CMD_SET_RATE
// PORTS
//   CLOCK_50    in   1  system clock
//   reset       in   1  asynchronous, active-low reset
//   start       in   1  1-cycle pulse: begin or restart the init sequence
//   tx_req      out  1  1-cycle pulse: transmit tx_byte (issued only while tx_busy=0)
//   tx_byte     out  8  command byte; held stable from tx_req until tx_busy falls
//   tx_busy     in   1  transmitter active; rises the cycle after tx_req, falls when the frame ends
//   rx_valid    in   1  1-cycle strobe: rx_byte holds a received byte
//   rx_byte     in   8  received byte (parity already checked by the receiver)
//   stream_en   out  1  device is in streaming mode; enables the packet datapath
//   init_done   out  1  sequence completed successfully (sticky until start or reset)
//   init_error  out  1  retries exhausted (sticky until start or reset)
//   retry_count out  2  failed attempts in the current sequence
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, step=0, timer=0, all outputs 0 (tx_byte=8'h00).
//   Steps: 0 = 0xFF RESET, 1 = 0xF3 SET_RATE, 2 = SAMPLE_RATE, 3 = 0xF4 ENABLE.
//   States:
//   - IDLE: on start, clear retry_count, step=0, go to SEND.
//   - SEND: once tx_busy=0, pulse tx_req with tx_byte=cmd[step] and go to TX_WAIT.
//   - TX_WAIT: on tx_busy falling, clear timer and go to WAIT_ACK.
//   - WAIT_ACK: timer counts each cycle.
//     - rx 0xFA: step 0 goes to WAIT_BAT (timer cleared); steps 1-2 do step++ and go to SEND;
//       step 3 goes to STREAM.
//     - rx 0xFE: counts a failure and resends the same step.
//     - rx 0xFC, any other byte, or timer==ACK_TIMEOUT-1: counts a failure and restarts from step 0.
//   - WAIT_BAT: rx 0xAA goes to WAIT_ID. rx 0xFC/other or timeout counts a failure and restarts
//     from step 0. Timer is not cleared between WAIT_BAT and WAIT_ID.
//   - WAIT_ID: rx 0x00 does step=1 and goes to SEND. Other byte or timeout counts a failure and
//     restarts from step 0.
//   - STREAM: stream_en=1, init_done=1; rx bytes are ignored here (they belong to the datapath).
//   - FAIL: init_error=1, stream_en=0, no tx_req.
//   Failure handling: retry_count++; if the new count equals MAX_RETRIES, go to FAIL, otherwise
//   retry as described above.
//   start in any state except IDLE: on the next cycle init_done, init_error and stream_en are 0,
//   retry_count=0, step=0 and state=SEND. A transmit already in flight is allowed to finish:
//   SEND waits for tx_busy=0.
//   Simultaneous rx_valid and timeout in the same cycle: the byte wins and the timeout is ignored.
//   rx_valid in IDLE/SEND/TX_WAIT/FAIL is discarded.
//   Timer width: $clog2(BAT_TIMEOUT+1). The timer saturates and never wraps.
//   tx_req is never asserted in two consecutive cycles.
//   Command-to-tx_req latency is 1 cycle when tx_busy=0.
// STRUCTURE
//   Shared package ps2_pkg holds:
//   - CMD_RESET=8'hFF, CMD_SET_RATE=8'hF3, CMD_ENABLE=8'hF4
//   - RSP_ACK=8'hFA, RSP_RESEND=8'hFE, RSP_ERROR=8'hFC, RSP_BAT_OK=8'hAA, ID_STD=8'h00
//   - localparam state encodings for this FSM
//   One sub-module, ps2_timeout_timer (clear / enable / limit -> expired), instantiated once.
//   FSM and step/retry registers live in this module.
// TESTING
//   Run with ACK_TIMEOUT=100, BAT_TIMEOUT=400, MAX_RETRIES=3, against a behavioural device model.
//   1 Happy path: reset, start, device answers FA,AA,00,FA,FA,FA -> tx bytes FF,F3,64,F4 in order;
//     stream_en=init_done=1, retry_count=0.
//   2 Device answers FE to F3 -> F3 resent, retry_count=1; sequence then completes with stream_en=1.
//   3 No response to any command -> FF sent 3 times, 100 cycles apart after TX end; then
//     init_error=1, stream_en=0, no further tx_req.
//   4 BAT returns FC -> retry_count=1, next tx_byte=FF; then normal completion.
//   5 reset=0 mid WAIT_BAT -> outputs 0 immediately. Separately: start pulse while in STREAM ->
//     stream_en=0 next cycle, FF transmitted.
//   6 rx_valid=FA in the same cycle as the ACK timeout -> treated as ACK; retry_count unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command/response bytes, init-sequencer state
// encodings and the step-to-command lookup.
package ps2_pkg;

    // Host-to-device command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Device-to-host response bytes
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] ID_STD     = 8'h00;

    // Init sequencer state encodings
    typedef logic [2:0] init_state_t;
    localparam init_state_t ST_IDLE     = 3'd0;
    localparam init_state_t ST_SEND     = 3'd1;
    localparam init_state_t ST_TX_WAIT  = 3'd2;
    localparam init_state_t ST_WAIT_ACK = 3'd3;
    localparam init_state_t ST_WAIT_BAT = 3'd4;
    localparam init_state_t ST_WAIT_ID  = 3'd5;
    localparam init_state_t ST_STREAM   = 3'd6;
    localparam init_state_t ST_FAIL     = 3'd7;

    // Sequence step indices
    localparam logic [1:0] STEP_RESET  = 2'd0;
    localparam logic [1:0] STEP_RATE   = 2'd1;
    localparam logic [1:0] STEP_ARG    = 2'd2;
    localparam logic [1:0] STEP_ENABLE = 2'd3;

    // Byte transmitted for a given sequence step; the rate argument is a parameter of the caller.
    function automatic logic [7:0] cmd_for_step(input logic [1:0] step, input logic [7:0] rate);
        logic [7:0] cmd;
        case (step)
            STEP_RESET:  cmd = CMD_RESET;
            STEP_RATE:   cmd = CMD_SET_RATE;
            STEP_ARG:    cmd = rate;
            default:     cmd = CMD_ENABLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating up-counter used for response timeouts. clear has priority over
// enable; expired is high while the count equals the supplied limit.
module ps2_timeout_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear to zero, otherwise count up and stick at all-ones
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer: sends RESET, SET_RATE + argument and ENABLE,
// validates each response with timeouts and bounded retries, then raises
// stream_en to open the movement-packet datapath.
//
// Transmit handshake: tx_req is a one-cycle request issued only while
// tx_busy=0; the transmitter raises tx_busy the following cycle and drops it
// when the frame ends. tx_byte is valid in the tx_req cycle and held until the
// next request. rx_valid is a one-cycle strobe qualifying rx_byte; it is only
// consumed in the WAIT_* states.
module ps2_mouse_init_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned BAT_TIMEOUT = 37_500_000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       stream_en,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] retry_count,
    output logic [2:0] state_dbg
);

    localparam int unsigned   TW        = $clog2(BAT_TIMEOUT + 1);
    localparam logic [TW-1:0] ACK_LIMIT = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LIMIT = TW'(BAT_TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    init_state_t state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  retry_q, retry_d;
    logic [7:0]  tx_byte_q;
    logic        busy_q;

    logic          fail;
    logic          resend_same;
    logic [1:0]    retry_inc;
    logic [7:0]    cmd;
    logic          timer_clear;
    logic          timer_en;
    logic [TW-1:0] timer_limit;
    logic          timer_expired;

    assign cmd = cmd_for_step(step_q, SAMPLE_RATE);

    // Timer runs only while awaiting a response; it is kept cleared elsewhere and is
    // restarted when leaving WAIT_ACK so the BAT window spans WAIT_BAT and WAIT_ID together.
    always_comb begin
        timer_en    = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_BAT) ||
                      (state_q == ST_WAIT_ID);
        timer_clear = !timer_en || ((state_q == ST_WAIT_ACK) && (state_d != ST_WAIT_ACK));
        timer_limit = (state_q == ST_WAIT_ACK) ? ACK_LIMIT : BAT_LIMIT;
    end

    ps2_timeout_timer #(
        .W (TW)
    ) u_timer (
        .clk_i     (CLOCK_50),
        .rst_ni    (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .limit_i   (timer_limit),
        .expired_o (timer_expired)
    );

    // State, step, retry and transmit bookkeeping registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            step_q    <= STEP_RESET;
            retry_q   <= 2'd0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            busy_q  <= tx_busy;
            if (tx_req) begin
                tx_byte_q <= cmd;
            end
        end
    end

    // Next-state logic; a received byte takes precedence over a same-cycle timeout
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        fail        = 1'b0;
        resend_same = 1'b0;
        retry_inc   = retry_q + 2'd1;
        if (start) begin
            state_d = ST_SEND;
            step_d  = STEP_RESET;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_SEND: begin
                    if (!tx_busy) state_d = ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (busy_q && !tx_busy) state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (rx_valid) begin
                        case (rx_byte)
                            RSP_ACK: begin
                                if (step_q == STEP_RESET) begin
                                    state_d = ST_WAIT_BAT;
                                end else if (step_q == STEP_ENABLE) begin
                                    state_d = ST_STREAM;
                                end else begin
                                    step_d  = step_q + 2'd1;
                                    state_d = ST_SEND;
                                end
                            end
                            RSP_RESEND: begin
                                fail        = 1'b1;
                                resend_same = 1'b1;
                            end
                            RSP_ERROR: fail = 1'b1;
                            default:   fail = 1'b1;
                        endcase
                    end else if (timer_expired) begin
                        fail = 1'b1;
                    end
                end
                ST_WAIT_BAT: begin
                    if (rx_valid) begin
                        if (rx_byte == RSP_BAT_OK) state_d = ST_WAIT_ID;
                        else                       fail    = 1'b1;
                    end else if (timer_expired) begin
                        fail = 1'b1;
                    end
                end
                ST_WAIT_ID: begin
                    if (rx_valid) begin
                        if (rx_byte == ID_STD) begin
                            step_d  = STEP_RATE;
                            state_d = ST_SEND;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (timer_expired) begin
                        fail = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
            if (fail) begin
                retry_d = retry_inc;
                if (retry_inc == RETRY_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_SEND;
                    if (!resend_same) step_d = STEP_RESET;
                end
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        tx_req      = (state_q == ST_SEND) && !tx_busy;
        tx_byte     = tx_req ? cmd : tx_byte_q;
        stream_en   = (state_q == ST_STREAM);
        init_done   = (state_q == ST_STREAM);
        init_error  = (state_q == ST_FAIL);
        retry_count = retry_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for the PS/2 mouse init sequencer with a scripted device model.
module tb_ps2_mouse_init_ctrl;
    import ps2_pkg::*;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       stream_en;
    logic       init_done;
    logic       init_error;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    ps2_mouse_init_ctrl #(
        .ACK_TIMEOUT (100),
        .BAT_TIMEOUT (400),
        .MAX_RETRIES (3),
        .SAMPLE_RATE (8'd100)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .tx_req      (tx_req),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .stream_en   (stream_en),
        .init_done   (init_done),
        .init_error  (init_error),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    // Clock
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    // Device model transmit side: wait for tx_req, check the byte against the expected
    // queue, play a busy frame, and return once the DUT is listening for a response.
    task automatic do_tx(output int wait_cycles);
        logic [7:0] exp;
        int n;
        exp = exp_q.pop_front();
        n = 0;
        while (tx_req !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        wait_cycles = n;
        checks++;
        if (tx_req !== 1'b1) begin
            errors++;
            $display("FAIL tx_req_seen: no tx_req within %0d cycles, expected byte %h", n, exp);
        end else if (tx_byte !== exp) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", tx_byte, exp);
        end
        tick();
        tx_busy = 1'b1;
        repeat (6) tick();
        checks++;
        if (tx_byte !== exp || tx_req !== 1'b0) begin
            errors++;
            $display("FAIL tx_hold: byte %h req %b expected byte %h req 0", tx_byte, tx_req, exp);
        end
        tx_busy = 1'b0;
        tick();
    endtask

    // Full successful exchange starting from a freshly started sequence
    task automatic run_ok_sequence();
        int w;
        exp_q.push_back(8'hFF); exp_q.push_back(8'hF3);
        exp_q.push_back(8'h64); exp_q.push_back(8'hF4);
        do_tx(w); send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        tx_busy  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) tick();
        checks++;
        if ({tx_req, tx_byte, stream_en, init_done, init_error, retry_count, state_dbg} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b byte=%h se=%b done=%b err=%b rc=%0d st=%0d expected all 0",
                     tx_req, tx_byte, stream_en, init_done, init_error, retry_count, state_dbg);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || tx_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: st=%0d req=%b expected st=0 req=0", state_dbg, tx_req);
        end
    endtask

    task automatic test_happy_path();
        pulse_start();
        checks++;
        if (tx_req !== 1'b1 || tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL start_latency: req=%b byte=%h expected req=1 byte=ff", tx_req, tx_byte);
        end
        run_ok_sequence();
        checks++;
        if (stream_en !== 1'b1 || init_done !== 1'b1 || init_error !== 1'b0 || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL happy_done: se=%b done=%b err=%b rc=%0d expected 1 1 0 0",
                     stream_en, init_done, init_error, retry_count);
        end
        // Bytes arriving while streaming belong to the datapath
        send_rx(8'hFE);
        send_rx(8'h08);
        checks++;
        if (stream_en !== 1'b1 || retry_count !== 2'd0 || tx_req !== 1'b0) begin
            errors++;
            $display("FAIL stream_ignores_rx: se=%b rc=%0d req=%b expected 1 0 0", stream_en, retry_count, tx_req);
        end
    endtask

    task automatic test_resend();
        int w;
        pulse_start();
        checks++;
        if (stream_en !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears: se=%b done=%b expected 0 0", stream_en, init_done);
        end
        exp_q.push_back(8'hFF); exp_q.push_back(8'hF3);
        do_tx(w); send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
        do_tx(w); send_rx(8'hFE);
        checks++;
        if (retry_count !== 2'd1) begin
            errors++;
            $display("FAIL resend_count: got %0d expected 1", retry_count);
        end
        exp_q.push_back(8'hF3); exp_q.push_back(8'h64); exp_q.push_back(8'hF4);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
        checks++;
        if (stream_en !== 1'b1 || retry_count !== 2'd1) begin
            errors++;
            $display("FAIL resend_done: se=%b rc=%0d expected 1 1", stream_en, retry_count);
        end
    endtask

    task automatic test_no_response();
        int w;
        int reqs;
        pulse_start();
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        do_tx(w);
        for (int i = 0; i < 2; i++) begin
            do_tx(w);
            checks++;
            if (w !== 100) begin
                errors++;
                $display("FAIL retry_spacing: got %0d cycles expected 100", w);
            end
        end
        repeat (100) tick();
        checks++;
        if (init_error !== 1'b1 || stream_en !== 1'b0 || retry_count !== 2'd3 || state_dbg !== ST_FAIL) begin
            errors++;
            $display("FAIL exhausted: err=%b se=%b rc=%0d st=%0d expected 1 0 3 7",
                     init_error, stream_en, retry_count, state_dbg);
        end
        reqs = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_req === 1'b1) reqs++;
            tick();
        end
        checks++;
        if (reqs != 0 || init_error !== 1'b1) begin
            errors++;
            $display("FAIL fail_quiet: got %0d tx_req err=%b expected 0 and err=1", reqs, init_error);
        end
    endtask

    task automatic test_bat_error();
        int w;
        pulse_start();
        checks++;
        if (init_error !== 1'b0 || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL start_clears_error: err=%b rc=%0d expected 0 0", init_error, retry_count);
        end
        exp_q.push_back(8'hFF);
        do_tx(w); send_rx(8'hFA); send_rx(8'hFC);
        checks++;
        if (retry_count !== 2'd1 || tx_req !== 1'b1 || tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL bat_error_restart: rc=%0d req=%b byte=%h expected 1 1 ff", retry_count, tx_req, tx_byte);
        end
        run_ok_sequence();
        checks++;
        if (stream_en !== 1'b1 || retry_count !== 2'd1) begin
            errors++;
            $display("FAIL bat_error_done: se=%b rc=%0d expected 1 1", stream_en, retry_count);
        end
    endtask

    task automatic test_async_reset_and_restart();
        int w;
        pulse_start();
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        do_tx(w); send_rx(8'hFE);
        do_tx(w); send_rx(8'hFA);
        checks++;
        if (state_dbg !== ST_WAIT_BAT || retry_count !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset: st=%0d rc=%0d expected 4 1", state_dbg, retry_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({tx_req, tx_byte, stream_en, init_done, init_error, retry_count, state_dbg} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b byte=%h se=%b done=%b err=%b rc=%0d st=%0d expected all 0",
                     tx_req, tx_byte, stream_en, init_done, init_error, retry_count, state_dbg);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        pulse_start();
        run_ok_sequence();
        pulse_start();
        checks++;
        if (stream_en !== 1'b0 || init_done !== 1'b0 || tx_req !== 1'b1 || tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL start_in_stream: se=%b done=%b req=%b byte=%h expected 0 0 1 ff",
                     stream_en, init_done, tx_req, tx_byte);
        end
    endtask

    task automatic test_ack_at_timeout();
        int w;
        pulse_start();
        exp_q.push_back(8'hFF);
        do_tx(w);
        repeat (99) tick();
        send_rx(8'hFA);
        checks++;
        if (state_dbg !== ST_WAIT_BAT || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL ack_vs_timeout: st=%0d rc=%0d expected 4 0", state_dbg, retry_count);
        end
        send_rx(8'hAA); send_rx(8'h00);
        exp_q.push_back(8'hF3); exp_q.push_back(8'h64); exp_q.push_back(8'hF4);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
        do_tx(w); send_rx(8'hFA);
        checks++;
        if (stream_en !== 1'b1 || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL ack_at_timeout_done: se=%b rc=%0d expected 1 0", stream_en, retry_count);
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_resend();
        test_no_response();
        test_bat_error();
        test_async_reset_and_restart();
        test_ack_at_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
